falc56_bus_ctrl: RTL and testbench
==================================

FALC56_BUS_CTRL -- requirements
Module: falc56_bus_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; CLK_I is the clock and RSTn_I is the reset (all state clears immediately when RSTn_I is low).
REQ-002 Parameter ALE_CYC, default 2: number of cycles ALE is high (1..15).
REQ-003 Parameter STROBE_CYC, default 4: number of cycles RDn or WRn is low (1..15).
REQ-004 Parameter HOLD_CYC, default 2: number of cycles after strobe release with CSn still low (1..15).
REQ-005 CLK_I  in  1  system clock.
REQ-006 RSTn_I  in  1  asynchronous active-low reset.
REQ-007 REQ_I  in  1  host access request.
REQ-008 WE_I  in  1  1=write, 0=read.
REQ-009 CHIP_I  in  1  framer select: 0 selects CSn[0], 1 selects CSn[1].
REQ-010 ADDR_I  in  8  register address.
REQ-011 WDATA_I  in  8  write data.
REQ-012 BUSY_O  out  1  access in progress.
REQ-013 ACK_O  out  1  one-cycle completion pulse.
REQ-014 RDATA_O  out  8  read data, valid while ACK_O is high and held until the next read completes.
REQ-015 IRQ_O  out  2  framer interrupt levels, one bit per chip.
REQ-016 F56_BADD_O  out  8  address/data driven toward the PHY.
REQ-017 F56_BADD_I  in  8  bus value returned from the PHY.
REQ-018 F56_BADD_DIR_O  out  1  1 drives the bus, 0 releases it.
REQ-019 F56_ALE_O, F56_RDn_O, F56_WRn_O  out  1 each  bus strobes.
REQ-020 F56_CSn_O  out  2  chip selects, active low.
REQ-021 F56_INT_I  in  2  framer interrupt lines.

Function
REQ-022 State machine states: IDLE, ADDR, ALAT, STRB, HOLD, DONE.
REQ-023 In IDLE with REQ_I=1, the block SHALL latch WE_I, CHIP_I, ADDR_I and WDATA_I at that edge and enter ADDR; REQ_I is ignored in every other state.
REQ-024 BUSY_O SHALL be 1 in every state except IDLE.
REQ-025 ADDR state, ALE_CYC cycles: F56_BADD_O=address, DIR=1, ALE=1, and the selected CSn bit is 0.
REQ-026 ALAT state, 1 cycle: ALE=0 while the address is still driven, giving address hold time.
REQ-027 STRB state, STROBE_CYC cycles, write access: WRn=0, DIR=1, F56_BADD_O=data.
REQ-028 STRB state, STROBE_CYC cycles, read access: RDn=0, DIR=0; the block SHALL capture F56_BADD_I at the edge that ends the last STRB cycle.
REQ-029 HOLD state, HOLD_CYC cycles: both strobes are high and CSn stays asserted; on a write, data keeps being driven with DIR=1; on a read, DIR=0.
REQ-030 DONE state, 1 cycle: all CSn=2'b11, DIR=0, ACK_O=1, RDATA_O updated if the access was a read; the next state is IDLE.
REQ-031 Latency from the accepting edge to ACK_O SHALL be ALE_CYC+STROBE_CYC+HOLD_CYC+2 cycles, which is 10 with default parameters.
REQ-032 RDn and WRn SHALL never be low together; ALE SHALL never be high while a strobe is low.
REQ-033 Phase counters SHALL be 4 bits wide and SHALL reload on each state entry; no counter wraps.
REQ-034 A request arriving in DONE is not accepted; the earliest next acceptance is the IDLE cycle immediately after DONE.
REQ-035 In IDLE, outputs SHALL be: ALE=0, RDn=1, WRn=1, CSn=2'b11, DIR=0, F56_BADD_O=8'h00.

Reset
REQ-036 While RSTn_I=0, regardless of state, the block SHALL force: state IDLE, ALE=0, RDn=1, WRn=1, CSn=2'b11, DIR=0, F56_BADD_O=0, BUSY_O=0, ACK_O=0, RDATA_O=0, IRQ_O=0.
REQ-037 Reset during an access SHALL abort it with no ACK_O.

Configuration
REQ-038 With macro FALC56_INT_SYNC_EN defined, F56_INT_I SHALL pass through a two-flop synchronizer (reset value 0) before IRQ_O, giving 2 cycles of latency.
REQ-039 Without FALC56_INT_SYNC_EN, IRQ_O SHALL equal F56_INT_I combinationally.

Verification
REQ-040 Write test, defaults: REQ_I=1, WE_I=1, CHIP_I=0, ADDR_I=8'h3C, WDATA_I=8'hA5. Expected: ALE high 2 cycles with BADD=3C; 1 ALAT cycle; WRn low 4 cycles with BADD=A5 and DIR=1; CSn=2'b10 throughout; ACK_O in cycle 10.
REQ-041 Read test: CHIP_I=1, ADDR_I=8'h12, PHY returns 8'h5A during STRB. Expected: RDn low 4 cycles, DIR=0 during STRB, CSn=2'b01, RDATA_O=8'h5A with ACK_O.
REQ-042 Back-to-back test: REQ_I held high for 30 cycles. Expected: ACK_O every 11 cycles, BUSY_O low exactly 1 cycle between accesses.
REQ-043 Reset mid-access: assert RSTn_I=0 in cycle 5 of a write. Expected: WRn=1, CSn=2'b11, DIR=0 immediately; no ACK_O; a subsequent read completes normally.
REQ-044 Interrupt test: drive F56_INT_I=2'b10. Expected: IRQ_O=2'b10 after 2 edges with FALC56_INT_SYNC_EN, or at once without it.
REQ-045 Protocol check: an assertion runs across all tests and SHALL fail if RDn and WRn are both low, if ALE is high with a strobe low, or if a strobe is low while CSn=2'b11.

Source files
------------

// File: rtl/falc56_bus_ctrl.sv
// falc56_bus_ctrl: host-side bus controller for a FALC56 framer pair.
// Each accepted request runs one multiplexed address/data cycle:
// ADDR (ALE) -> ALAT -> STRB (RDn or WRn) -> HOLD -> DONE (ACK).
// Optional feature macro: FALC56_INT_SYNC_EN adds a two-flop synchronizer
// on the framer interrupt lines. Without it, IRQ_O follows F56_INT_I directly.
`timescale 1ns/1ps
module falc56_bus_ctrl #(
    parameter int ALE_CYC    = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic       CLK_I,
    input  logic       RSTn_I,
    input  logic       REQ_I,
    input  logic       WE_I,
    input  logic       CHIP_I,
    input  logic [7:0] ADDR_I,
    input  logic [7:0] WDATA_I,
    output logic       BUSY_O,
    output logic       ACK_O,
    output logic [7:0] RDATA_O,
    output logic [1:0] IRQ_O,
    output logic [7:0] F56_BADD_O,
    input  logic [7:0] F56_BADD_I,
    output logic       F56_BADD_DIR_O,
    output logic       F56_ALE_O,
    output logic       F56_RDn_O,
    output logic       F56_WRn_O,
    output logic [1:0] F56_CSn_O,
    input  logic [1:0] F56_INT_I
);

    typedef enum logic [2:0] {IDLE, ADDR, ALAT, STRB, HOLD, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic        we_r;
    logic        chip_r;
    logic [7:0]  addr_r;
    logic [7:0]  wdata_r;
    logic [7:0]  rd_cap;
    logic [1:0]  cs_sel;

    // Counter preload for a phase; counts down to zero, so it holds length-1.
    function automatic logic [3:0] phase_len(input state_t s);
        case (s)
            ADDR:    phase_len = 4'(ALE_CYC - 1);
            STRB:    phase_len = 4'(STROBE_CYC - 1);
            HOLD:    phase_len = 4'(HOLD_CYC - 1);
            default: phase_len = 4'd0;
        endcase
    endfunction

    assign cs_sel = chip_r ? 2'b01 : 2'b10;

    // State register; reset aborts any access in flight.
    always_ff @(posedge CLK_I or negedge RSTn_I) begin
        if (!RSTn_I) state <= IDLE;
        else         state <= state_nx;
    end

    // Phase counter reloads on every state change and parks at zero.
    always_ff @(posedge CLK_I or negedge RSTn_I) begin
        if (!RSTn_I)                cnt <= 4'd0;
        else if (state_nx != state) cnt <= phase_len(state_nx);
        else if (cnt != 4'd0)       cnt <= cnt - 4'd1;
    end

    // Request fields are captured only on the accepting edge in IDLE.
    always_ff @(posedge CLK_I or negedge RSTn_I) begin
        if (!RSTn_I) begin
            we_r    <= 1'b0;
            chip_r  <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else if (state == IDLE && REQ_I) begin
            we_r    <= WE_I;
            chip_r  <= CHIP_I;
            addr_r  <= ADDR_I;
            wdata_r <= WDATA_I;
        end
    end

    // Read data sampled at the edge closing the strobe, published entering DONE.
    always_ff @(posedge CLK_I or negedge RSTn_I) begin
        if (!RSTn_I) begin
            rd_cap  <= 8'h00;
            RDATA_O <= 8'h00;
        end else begin
            if (state == STRB && cnt == 4'd0 && !we_r) rd_cap <= F56_BADD_I;
            if (state == HOLD && state_nx == DONE && !we_r) RDATA_O <= rd_cap;
        end
    end

    // Next-state and bus outputs decoded from the current phase.
    always_comb begin
        state_nx       = state;
        BUSY_O         = (state != IDLE);
        ACK_O          = 1'b0;
        F56_BADD_O     = 8'h00;
        F56_BADD_DIR_O = 1'b0;
        F56_ALE_O      = 1'b0;
        F56_RDn_O      = 1'b1;
        F56_WRn_O      = 1'b1;
        F56_CSn_O      = 2'b11;
        case (state)
            IDLE: begin
                if (REQ_I) state_nx = ADDR;
            end
            ADDR: begin
                F56_BADD_O     = addr_r;
                F56_BADD_DIR_O = 1'b1;
                F56_ALE_O      = 1'b1;
                F56_CSn_O      = cs_sel;
                if (cnt == 4'd0) state_nx = ALAT;
            end
            ALAT: begin
                F56_BADD_O     = addr_r;
                F56_BADD_DIR_O = 1'b1;
                F56_CSn_O      = cs_sel;
                state_nx       = STRB;
            end
            STRB: begin
                F56_CSn_O = cs_sel;
                if (we_r) begin
                    F56_WRn_O      = 1'b0;
                    F56_BADD_DIR_O = 1'b1;
                    F56_BADD_O     = wdata_r;
                end else begin
                    F56_RDn_O = 1'b0;
                end
                if (cnt == 4'd0) state_nx = HOLD;
            end
            HOLD: begin
                F56_CSn_O = cs_sel;
                if (we_r) begin
                    F56_BADD_DIR_O = 1'b1;
                    F56_BADD_O     = wdata_r;
                end
                if (cnt == 4'd0) state_nx = DONE;
            end
            DONE: begin
                ACK_O    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef FALC56_INT_SYNC_EN
    logic [1:0] int_s1;
    logic [1:0] int_s2;

    // Two-flop synchronizer for the asynchronous framer interrupt lines.
    always_ff @(posedge CLK_I or negedge RSTn_I) begin
        if (!RSTn_I) begin
            int_s1 <= 2'b00;
            int_s2 <= 2'b00;
        end else begin
            int_s1 <= F56_INT_I;
            int_s2 <= int_s1;
        end
    end

    assign IRQ_O = int_s2;
`else
    // Direct pass-through, held at zero while reset is asserted.
    assign IRQ_O = RSTn_I ? F56_INT_I : 2'b00;
`endif

endmodule

// File: tb/tb_falc56_bus_ctrl.sv
// Scoreboard bench for falc56_bus_ctrl with a behavioural PHY register model.
`timescale 1ns/1ps
module tb_falc56_bus_ctrl;

    localparam int ALE_CYC    = 2;
    localparam int STROBE_CYC = 4;
    localparam int HOLD_CYC   = 2;
    localparam int LAT        = ALE_CYC + STROBE_CYC + HOLD_CYC + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_i = 1'b0;
    logic       we_i = 1'b0;
    logic       chip_i = 1'b0;
    logic [7:0] addr_i = 8'h00;
    logic [7:0] wdata_i = 8'h00;
    logic [1:0] int_in = 2'b00;
    logic       busy, ack;
    logic [7:0] rdata;
    logic [1:0] irq;
    logic [7:0] badd_o, badd_i;
    logic       dir, ale, rdn, wrn;
    logic [1:0] csn;

    falc56_bus_ctrl #(.ALE_CYC(ALE_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)) dut (
        .CLK_I(clk), .RSTn_I(rst_n), .REQ_I(req_i), .WE_I(we_i), .CHIP_I(chip_i),
        .ADDR_I(addr_i), .WDATA_I(wdata_i), .BUSY_O(busy), .ACK_O(ack), .RDATA_O(rdata),
        .IRQ_O(irq), .F56_BADD_O(badd_o), .F56_BADD_I(badd_i), .F56_BADD_DIR_O(dir),
        .F56_ALE_O(ale), .F56_RDn_O(rdn), .F56_WRn_O(wrn), .F56_CSn_O(csn), .F56_INT_I(int_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       chip;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [2][256];
    logic [7:0] phy_mem [2][256];
    logic [7:0] phy_addr = 8'h00;
    logic       phy_chip = 1'b0;

    function automatic logic [7:0] init_val(input int c, input int a);
        return 8'((a * 7 + c * 13) ^ 8'h5C);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // PHY model: latches address while ALE is high, stores on write strobe.
    initial begin
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 256; a++) phy_mem[c][a] = init_val(c, a);
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ale) begin
                    phy_addr = badd_o;
                    phy_chip = (csn == 2'b01);
                end
                if (!wrn && dir) phy_mem[phy_chip][phy_addr] = badd_o;
            end
        end
    end

    assign badd_i = !rdn ? phy_mem[phy_chip][phy_addr] : 8'hEE;

    // Monitor: protocol rules every cycle, scoreboard pop on each ACK.
    int         busy_cyc = 0, ale_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    logic [1:0] cs_first = 2'b11;
    logic       cs_var = 1'b0;
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cyc = 0; ale_cnt = 0; wr_cnt = 0; rd_cnt = 0;
                cs_first = 2'b11; cs_var = 1'b0;
            end else begin
                if ((!rdn && !wrn) || (ale && (!rdn || !wrn)) || ((!rdn || !wrn) && csn == 2'b11)
                    || (!wrn && !dir) || (!rdn && dir)) begin
                    n_err++;
                    $display("FAIL protocol: ale=%b rdn=%b wrn=%b csn=%b dir=%b at %0t", ale, rdn, wrn, csn, dir, $time);
                end
                if (!busy && (ale || !rdn || !wrn || csn != 2'b11 || dir || badd_o != 8'h00)) begin
                    n_err++;
                    $display("FAIL idle_outputs: ale=%b rdn=%b wrn=%b csn=%b dir=%b badd=%h", ale, rdn, wrn, csn, dir, badd_o);
                end
                if (busy) begin
                    busy_cyc++;
                    ale_cnt += int'(ale);
                    wr_cnt  += int'(!wrn);
                    rd_cnt  += int'(!rdn);
                    if (!ack) begin
                        if (busy_cyc == 1) cs_first = csn;
                        else if (csn != cs_first) cs_var = 1'b1;
                    end
                end
                if (ack) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_ack: got ack, expected none at %0t", $time);
                    end else begin
                        t = exp_q.pop_front();
                        check("latency", busy_cyc, LAT);
                        check("ale_cycles", ale_cnt, ALE_CYC);
                        check("wr_cycles", wr_cnt, t.we ? STROBE_CYC : 0);
                        check("rd_cycles", rd_cnt, t.we ? 0 : STROBE_CYC);
                        check("cs_select", {cs_var, cs_first}, {1'b0, t.chip ? 2'b01 : 2'b10});
                        check("done_bus", {csn, dir}, 3'b110);
                        if (!t.we) check("rdata", rdata, t.data);
                    end
                    busy_cyc = 0; ale_cnt = 0; wr_cnt = 0; rd_cnt = 0;
                    cs_first = 2'b11; cs_var = 1'b0;
                end
            end
        end
    end

    // Record the expected outcome of an access being accepted.
    task automatic push_exp(input logic t_we, input logic t_chip, input logic [7:0] t_addr, input logic [7:0] t_data);
        txn_t t;
        t.we = t_we; t.chip = t_chip; t.addr = t_addr;
        t.data = t_we ? t_data : ref_mem[t_chip][t_addr];
        if (t_we) ref_mem[t_chip][t_addr] = t_data;
        exp_q.push_back(t);
    endtask

    // Issue one access from an IDLE-cycle negedge; returns at the next IDLE negedge.
    task automatic do_txn(input logic t_we, input logic t_chip, input logic [7:0] t_addr, input logic [7:0] t_data);
        int n;
        req_i = 1'b1; we_i = t_we; chip_i = t_chip; addr_i = t_addr; wdata_i = t_data;
        push_exp(t_we, t_chip, t_addr, t_data);
        @(negedge clk);
        n = 1;
        while (!ack && n < LAT + 5) begin
            req_i = 1'($urandom); {we_i, chip_i} = 2'($urandom);
            addr_i = 8'($urandom); wdata_i = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (!ack) begin
            n_vec++; n_err++;
            $display("FAIL ack_timeout: got no ack after %0d cycles, expected %0d", n, LAT);
            exp_q.delete();
        end
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, prev, acks;
        logic [7:0] a, d;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 256; k++) ref_mem[c][k] = init_val(c, k);

        int_in = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_busy_ack", {busy, ack}, 2'b00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_strobes", {ale, rdn, wrn, dir}, 4'b0110);
        check("rst_csn", csn, 2'b11);
        check("rst_badd", badd_o, 8'h00);
        check("rst_irq", irq, 2'b00);
        int_in = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b1, 1'b0, 8'h3C, 8'hA5);
        do_txn(1'b1, 1'b1, 8'h12, 8'h5A);
        do_txn(1'b0, 1'b1, 8'h12, 8'h00);
        do_txn(1'b0, 1'b0, 8'h3C, 8'h00);

        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            do_txn(1'($urandom), 1'($urandom), a, d);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // REQ held high: one access per 11 cycles, one idle cycle between.
        req_i = 1'b1; we_i = 1'b1; chip_i = 1'b0; addr_i = 8'h21; wdata_i = 8'hC3;
        push_exp(1'b1, 1'b0, 8'h21, 8'hC3);
        cyc = 0; prev = 0;
        for (int k = 0; k < 3; k++) begin
            do begin @(negedge clk); cyc++; end while (!ack && cyc < prev + LAT + 5);
            check("b2b_ack_period", cyc - prev, LAT + (k > 0 ? 1 : 0));
            prev = cyc;
            @(negedge clk); cyc++;
            check("b2b_idle_gap", busy, 1'b0);
            if (k < 2) begin
                we_i = 1'(k); chip_i = 1'b1; addr_i = 8'h21; wdata_i = 8'h3C;
                push_exp(1'(k), 1'b1, 8'h21, 8'h3C);
                @(negedge clk); cyc++;
                check("b2b_busy_again", busy, 1'b1);
            end else begin
                req_i = 1'b0;
            end
        end
        @(negedge clk);

        // Interrupt path.
        int_in = 2'b10;
`ifdef FALC56_INT_SYNC_EN
        @(posedge clk); #1;
        check("irq_one_edge", irq, 2'b00);
        @(posedge clk); #1;
        check("irq_sync", irq, 2'b10);
`else
        #1;
        check("irq_comb", irq, 2'b10);
`endif
        int_in = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        check("irq_chip0", irq, 2'b01);
        int_in = 2'b00;
        @(negedge clk);

        // Reset in cycle 5 of a write aborts it without ACK.
        req_i = 1'b1; we_i = 1'b1; chip_i = 1'b0; addr_i = 8'h3C; wdata_i = 8'h77;
        repeat (5) begin @(negedge clk); req_i = 1'b0; end
        check("abort_in_strobe", wrn, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_bus", {wrn, csn, dir}, 4'b1110);
        check("abort_busy_ack", {busy, ack}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (12) begin @(negedge clk); acks += int'(ack); end
        check("abort_no_ack", acks, 0);
        do_txn(1'b0, 1'b1, 8'h12, 8'h00);
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
